instruction_fetch_controller: RTL and testbench
===============================================

// Module: instruction_fetch_controller
// PURPOSE
// - Fetch stage directly upstream of instruction_decode_controller. Holds a PC-indexed instruction store,
//   reads the word at the current PC, drives it plus a start pulse into decode, waits for decode completion,
//   then adopts the decode-supplied next PC and fetches again. Stops on a HALT opcode or when run drops.
// PARAMETERS
// - PC_W         5    PC width; store depth = 2**PC_W words
// - INSTR_W      59   instruction width (flag[58:57], opcode[56:52], rd, rs1, rs2, pc[36:32], imm[31:0])
// - RESET_PC     0    PC value after reset
// - HALT_OPCODE  31   opcode value in [56:52] that stops fetching
// - WDOG_CYCLES  255  watchdog limit in cycles; used only with FETCH_WATCHDOG_EN
// PORTS
// - clk                 in   1        clock, rising edge
// - rst                 in   1        synchronous active-high reset
// - run                 in   1        1 = fetch continuously; 0 = stop at next instruction boundary
// - load_en             in   1        write store word
// - load_addr           in   PC_W     store write address
// - load_data           in   INSTR_W  store write data
// - decode_busy         in   1        decode busy
// - decode_done         in   1        decode done
// - fetch_stage_enable  in   1        decode poll flag: ready for next instruction
// - next_pc_in          in   PC_W     next PC from decode
// - decode_start        out  1        start to decode
// - instruction         out  INSTR_W  instruction to decode, stable while decode_start=1
// - pc                  out  PC_W     current PC
// - fetch_busy          out  1        1 in FETCH/ISSUE/WAIT
// - halted              out  1        sticky; set on HALT opcode
// - instr_count         out  16       completed instructions, wraps at 2**16
// - fault               out  1        watchdog fault, sticky
// BEHAVIOUR
// - Reset: state=IDLE, pc=RESET_PC. All outputs are 0: decode_start, fetch_busy, halted, instr_count, fault;
//   instruction=0. Store contents are NOT reset. rst wins in any state, including mid-WAIT; decode is not told.
// - States and transitions:
//   - IDLE: if run=1 -> FETCH.
//   - FETCH: instr_q <= mem[pc] (synchronous read) -> ISSUE.
//   - ISSUE:
//     - If instr_q[56:52]==HALT_OPCODE -> HALTED; decode_start is never asserted.
//     - Else decode_start=1 and held every cycle until decode_busy=1 is sampled.
//       In that same edge, decode_start<=0 -> WAIT.
//   - WAIT: when decode_done=1 && fetch_stage_enable=1 && decode_busy=0:
//     - pc<=next_pc_in; instr_count++.
//     - -> FETCH if run=1, else -> IDLE.
//   - HALTED: halted=1, fetch_busy=0. Sticky until rst. run is ignored.
// - instruction output: instr_q with bits [36:32] overwritten by the current pc; stored PC field is don't-care.
// - Stale done: decode holds done/fetch_stage_enable high between instructions. WAIT is entered only after
//   decode_busy=1 is seen, so stale completion is never consumed.
// - Latency: run rise -> decode_start=1 two cycles later. Completion sampled -> next decode_start two cycles later.
// - PC wrap: next_pc_in is taken verbatim; 2**PC_W-1 -> 0 is legal. No internal increment.
// - load_en: honoured only in IDLE or HALTED; silently ignored otherwise.
//   A load to address pc in IDLE is seen by the next FETCH.
// - run=0 mid-instruction: the current instruction completes normally, then -> IDLE.
// CONFIGURATION
// - FETCH_WATCHDOG_EN defined:
//   - A cycle counter clears on entry to ISSUE and counts in ISSUE and WAIT.
//   - On reaching WDOG_CYCLES: state FAULT, fault=1, decode_start=0, fetch_busy=0. Sticky until rst.
// - FETCH_WATCHDOG_EN undefined: no counter, no FAULT state, fault tied 0.
// TESTING
// - Reset: rst 2 cycles -> pc=0, all outputs 0; mem written before reset still readable after.
// - Load mem[0]=ADD (opcode 0, imm 5) and mem[1]=HALT (opcode 31); run=1. Decode model: busy 1 cycle after
//   start, done 3 cycles later, next_pc_in=1. Expect:
//   - decode_start at cycle 2 after run, instruction[36:32]=0.
//   - then pc=1, instr_count=1.
//   - then halted=1, decode_start never reasserted.
// - Handshake: decode holds busy=0 for 5 cycles -> decode_start stays 1 for exactly 5+1 cycles, then drops;
//   done=1 with fetch_stage_enable=0 -> no advance.
// - Wrap: pc=31, next_pc_in=0 -> pc=0 and mem[0] fetched; load_en during WAIT leaves mem unchanged.
// - rst asserted in WAIT -> next cycle IDLE, pc=0, decode_start=0, instr_count=0, mem intact.
// - With FETCH_WATCHDOG_EN and WDOG_CYCLES=16: decode_busy never asserts -> fault=1 after 16 cycles in ISSUE,
//   decode_start=0. Without the macro: fault stays 0 and start stays 1 indefinitely.

Source files
------------

// File: rtl/instruction_fetch_controller.sv
// Purpose: fetch stage ahead of instruction_decode_controller. Reads the word at pc from a local
//          store, hands it to decode with a start pulse, then adopts decode's next_pc.
// Latency: run rise -> decode_start two cycles later; sampled completion -> next decode_start two cycles later.
// Backpressure: decode_start is held until decode_busy is seen. Completion is accepted only when
//               decode_done && fetch_stage_enable && !decode_busy.
// Optional feature: define FETCH_WATCHDOG_EN to add an ISSUE/WAIT watchdog (WDOG_CYCLES) with a sticky FAULT state.
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   run                       fetch continuously while 1; stop at the next instruction boundary when 0
//   load_en/addr/data         store write port (honoured only in IDLE or HALTED)
//   decode_busy/done          decode status
//   fetch_stage_enable        decode is ready for the next instruction
//   next_pc_in                next PC from decode
//   decode_start              start strobe to decode
//   instruction               word to decode, with the pc field replaced by the current pc
//   pc                        current PC
//   fetch_busy                1 while fetching, issuing or waiting on decode
//   halted                    sticky HALT indication
//   instr_count               completed instructions (wraps)
//   fault                     sticky watchdog fault (tied 0 without FETCH_WATCHDOG_EN)
module instruction_fetch_controller #(
  parameter int PC_W        = 5,
  parameter int INSTR_W     = 59,
  parameter int RESET_PC    = 0,
  parameter int HALT_OPCODE = 31,
  parameter int WDOG_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic               load_en,
  input  logic [PC_W-1:0]    load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               decode_busy,
  input  logic               decode_done,
  input  logic               fetch_stage_enable,
  input  logic [PC_W-1:0]    next_pc_in,
  output logic               decode_start,
  output logic [INSTR_W-1:0] instruction,
  output logic [PC_W-1:0]    pc,
  output logic               fetch_busy,
  output logic               halted,
  output logic [15:0]        instr_count,
  output logic               fault
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_HALTED
`ifdef FETCH_WATCHDOG_EN
    , S_FAULT
`endif
  } state_t;

  state_t state;

  logic [INSTR_W-1:0] mem [2**PC_W];
  logic [INSTR_W-1:0] instr_q;
  logic [INSTR_W-1:0] fetch_word;
  logic               fetch_is_halt;
  logic               issue_is_halt;
  logic               decode_complete;

  assign fetch_word      = mem[pc];
  // Deciding HALT on the word being fetched lets decode_start be registered on the
  // FETCH->ISSUE edge, so a HALT word never produces even a one-cycle start pulse.
  assign fetch_is_halt   = (fetch_word[56:52] == 5'(HALT_OPCODE));
  assign issue_is_halt   = (instr_q[56:52] == 5'(HALT_OPCODE));
  assign decode_complete = decode_done && fetch_stage_enable && !decode_busy;

  // Store is deliberately not reset; writes only while the fetch engine is parked.
  always_ff @(posedge clk) begin
    if (load_en && (state == S_IDLE || state == S_HALTED)) begin
      mem[load_addr] <= load_data;
    end
  end

  // Decode sees the live pc in the pc field; the stored field is ignored.
  always_comb begin
    instruction        = instr_q;
    instruction[36:32] = 5'(pc);
  end

`ifdef FETCH_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);
  logic [WDOG_W-1:0] wdog_cnt;
`else
  logic unused_wdog;
  assign unused_wdog = (WDOG_CYCLES != 0);
  assign fault       = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      pc           <= PC_W'(RESET_PC);
      instr_q      <= '0;
      decode_start <= 1'b0;
      fetch_busy   <= 1'b0;
      halted       <= 1'b0;
      instr_count  <= '0;
`ifdef FETCH_WATCHDOG_EN
      fault        <= 1'b0;
      wdog_cnt     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (run) begin
            state      <= S_FETCH;
            fetch_busy <= 1'b1;
          end
        end
        S_FETCH: begin
          instr_q      <= fetch_word;
          decode_start <= !fetch_is_halt;
          state        <= S_ISSUE;
`ifdef FETCH_WATCHDOG_EN
          wdog_cnt     <= '0;
`endif
        end
        S_ISSUE: begin
          if (issue_is_halt) begin
            state        <= S_HALTED;
            halted       <= 1'b1;
            fetch_busy   <= 1'b0;
            decode_start <= 1'b0;
          end else if (decode_busy) begin
            // Moving to WAIT only once busy is seen keeps a done level left over
            // from the previous instruction from being taken as completion.
            decode_start <= 1'b0;
            state        <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (decode_complete) begin
            pc          <= next_pc_in;
            instr_count <= instr_count + 16'd1;
            if (run) begin
              state <= S_FETCH;
            end else begin
              state      <= S_IDLE;
              fetch_busy <= 1'b0;
            end
          end
        end
        S_HALTED: begin
        end
`ifdef FETCH_WATCHDOG_EN
        S_FAULT: begin
        end
`endif
        default: begin
          state <= S_IDLE;
        end
      endcase
`ifdef FETCH_WATCHDOG_EN
      // Expiry overrides whatever the ISSUE/WAIT logic above decided this cycle.
      if (state == S_ISSUE || state == S_WAIT) begin
        if (wdog_cnt == WDOG_LAST) begin
          state        <= S_FAULT;
          fault        <= 1'b1;
          decode_start <= 1'b0;
          fetch_busy   <= 1'b0;
        end else begin
          wdog_cnt <= wdog_cnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Bench for instruction_fetch_controller: scenario tasks drive a hand-written decode partner and
// compare outputs against constants and a queue of expected instruction words.
module tb_instruction_fetch_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        load_en;
  logic [4:0]  load_addr;
  logic [58:0] load_data;
  logic        decode_busy;
  logic        decode_done;
  logic        fetch_stage_enable;
  logic [4:0]  next_pc_in;
  logic        decode_start;
  logic [58:0] instruction;
  logic [4:0]  pc;
  logic        fetch_busy;
  logic        halted;
  logic [15:0] instr_count;
  logic        fault;

  int vectors = 0;
  int miscompares = 0;
  logic [58:0] exp_q[$];
  logic [58:0] w_add, w_halt, w_h, w_a, w_b, w_c;

  instruction_fetch_controller #(
    .PC_W(5), .INSTR_W(59), .RESET_PC(0), .HALT_OPCODE(31), .WDOG_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .run(run), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .decode_busy(decode_busy), .decode_done(decode_done),
    .fetch_stage_enable(fetch_stage_enable), .next_pc_in(next_pc_in),
    .decode_start(decode_start), .instruction(instruction), .pc(pc),
    .fetch_busy(fetch_busy), .halted(halted), .instr_count(instr_count), .fault(fault)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not reach its summary");
    $fatal(1, "timeout");
  end

  function automatic logic [58:0] mk(input logic [4:0] op, input logic [31:0] imm);
    return {2'b10, op, 5'd3, 5'd4, 5'd5, 5'h1f, imm};
  endfunction

  function automatic logic [58:0] with_pc(input logic [58:0] w, input logic [4:0] p);
    logic [58:0] r;
    r = w;
    r[36:32] = p;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [4:0] a, input logic [58:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    step();
    load_en = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1; run = 1'b0; decode_busy = 1'b0; decode_done = 1'b0; fetch_stage_enable = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Bounded wait for decode_start; returns cycles waited (20 means timeout).
  task automatic wait_start(output int n);
    n = 0;
    while (decode_start !== 1'b1 && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    decode_busy = 1'b0; decode_done = 1'b0; fetch_stage_enable = 1'b0; next_pc_in = '0;
    step(); step();
    rst = 1'b0;
    vectors++; if (pc !== 5'd0) begin miscompares++; $display("FAIL reset_pc: got %0d want 0", pc); end
    vectors++; if (decode_start !== 1'b0) begin miscompares++; $display("FAIL reset_start: got %b want 0", decode_start); end
    vectors++; if (fetch_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", fetch_busy); end
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted: got %b want 0", halted); end
    vectors++; if (instr_count !== 16'd0) begin miscompares++; $display("FAIL reset_count: got %0d want 0", instr_count); end
    vectors++; if (fault !== 1'b0) begin miscompares++; $display("FAIL reset_fault: got %b want 0", fault); end
    vectors++; if (instruction !== 59'd0) begin miscompares++; $display("FAIL reset_instr: got %h want 0", instruction); end
  endtask

  task automatic test_basic();
    logic [58:0] e;
    int bad;
    w_add  = mk(5'd0, 32'd5);
    w_halt = mk(5'd31, 32'd0);
    do_load(5'd0, w_add);
    do_load(5'd1, w_halt);
    exp_q.push_back(with_pc(w_add, 5'd0));
    run = 1'b1;
    step();
    vectors++; if (decode_start !== 1'b0) begin miscompares++; $display("FAIL basic_start_early: got %b want 0", decode_start); end
    vectors++; if (fetch_busy !== 1'b1) begin miscompares++; $display("FAIL basic_fetch_busy: got %b want 1", fetch_busy); end
    step();
    vectors++; if (decode_start !== 1'b1) begin miscompares++; $display("FAIL basic_start_latency: got %b want 1", decode_start); end
    e = exp_q.pop_front();
    vectors++; if (instruction !== e) begin miscompares++; $display("FAIL basic_instr: got %h want %h", instruction, e); end
    decode_busy = 1'b1;
    step();
    vectors++; if (decode_start !== 1'b0) begin miscompares++; $display("FAIL basic_start_drop: got %b want 0", decode_start); end
    step(); step();
    decode_busy = 1'b0; decode_done = 1'b1; fetch_stage_enable = 1'b1; next_pc_in = 5'd1;
    step();
    vectors++; if (pc !== 5'd1) begin miscompares++; $display("FAIL basic_next_pc: got %0d want 1", pc); end
    vectors++; if (instr_count !== 16'd1) begin miscompares++; $display("FAIL basic_count: got %0d want 1", instr_count); end
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (decode_start !== 1'b0) bad++;
    end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL basic_halt_no_start: got %0d start cycles want 0", bad); end
    vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL basic_halted: got %b want 1", halted); end
    vectors++; if (fetch_busy !== 1'b0) begin miscompares++; $display("FAIL basic_halt_busy: got %b want 0", fetch_busy); end
    vectors++; if (instr_count !== 16'd1) begin miscompares++; $display("FAIL basic_halt_count: got %0d want 1", instr_count); end
    decode_done = 1'b0; fetch_stage_enable = 1'b0; run = 1'b0;
  endtask

  task automatic test_handshake();
    logic [58:0] e;
    int n;
    int cnt;
    apply_reset();
    w_h = mk(5'd2, 32'hDEADBEEF);
    do_load(5'd0, w_h);
    do_load(5'd2, mk(5'd31, 32'd0));
    exp_q.push_back(with_pc(w_h, 5'd0));
    // Stale completion left high from the previous instruction.
    decode_done = 1'b1; fetch_stage_enable = 1'b1; next_pc_in = 5'd7;
    run = 1'b1;
    wait_start(n);
    vectors++; if (n != 2) begin miscompares++; $display("FAIL hs_start_latency: got %0d cycles want 2", n); end
    e = exp_q.pop_front();
    vectors++; if (instruction !== e) begin miscompares++; $display("FAIL hs_instr: got %h want %h", instruction, e); end
    cnt = 0;
    while (decode_start === 1'b1 && cnt < 20) begin
      cnt++;
      if (cnt == 6) decode_busy = 1'b1;
      step();
    end
    vectors++; if (cnt != 6) begin miscompares++; $display("FAIL hs_start_width: got %0d cycles want 6", cnt); end
    vectors++; if (pc !== 5'd0) begin miscompares++; $display("FAIL hs_stale_done: got pc %0d want 0", pc); end
    decode_busy = 1'b0; fetch_stage_enable = 1'b0;
    step(); step(); step();
    vectors++; if (pc !== 5'd0 || instr_count !== 16'd0) begin
      miscompares++; $display("FAIL hs_fse_low_hold: got pc %0d count %0d want 0 0", pc, instr_count); end
    vectors++; if (fetch_busy !== 1'b1) begin miscompares++; $display("FAIL hs_wait_busy: got %b want 1", fetch_busy); end
    fetch_stage_enable = 1'b1; next_pc_in = 5'd2;
    step();
    vectors++; if (pc !== 5'd2 || instr_count !== 16'd1) begin
      miscompares++; $display("FAIL hs_advance: got pc %0d count %0d want 2 1", pc, instr_count); end
    decode_done = 1'b0; fetch_stage_enable = 1'b0;
    step(); step();
    vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL hs_halted: got %b want 1", halted); end
    run = 1'b0;
  endtask

  task automatic complete(input logic [4:0] npc);
    decode_busy = 1'b0; decode_done = 1'b1; fetch_stage_enable = 1'b1; next_pc_in = npc;
    step();
    decode_done = 1'b0; fetch_stage_enable = 1'b0;
  endtask

  task automatic test_wrap_and_stop();
    logic [58:0] e;
    int n;
    int bad;
    apply_reset();
    w_a = mk(5'd4, 32'h1234);
    w_b = mk(5'd3, 32'h55);
    do_load(5'd0, w_a);
    do_load(5'd31, w_b);
    exp_q.push_back(with_pc(w_a, 5'd0));
    exp_q.push_back(with_pc(w_b, 5'd31));
    exp_q.push_back(with_pc(w_a, 5'd0));
    run = 1'b1;
    wait_start(n);
    vectors++; if (n >= 20) begin miscompares++; $display("FAIL wrap_start0_timeout: got %0d cycles want <20", n); end
    e = exp_q.pop_front();
    vectors++; if (instruction !== e) begin miscompares++; $display("FAIL wrap_instr0: got %h want %h", instruction, e); end
    decode_busy = 1'b1; step();
    complete(5'd31);
    vectors++; if (pc !== 5'd31) begin miscompares++; $display("FAIL wrap_pc31: got %0d want 31", pc); end
    wait_start(n);
    e = exp_q.pop_front();
    vectors++; if (instruction !== e) begin miscompares++; $display("FAIL wrap_instr31: got %h want %h", instruction, e); end
    decode_busy = 1'b1; step();
    // Load while in WAIT must be dropped.
    do_load(5'd0, mk(5'd7, 32'hFFFF));
    complete(5'd0);
    vectors++; if (pc !== 5'd0) begin miscompares++; $display("FAIL wrap_pc0: got %0d want 0", pc); end
    wait_start(n);
    e = exp_q.pop_front();
    vectors++; if (instruction !== e) begin miscompares++; $display("FAIL wrap_mem_unchanged: got %h want %h", instruction, e); end
    decode_busy = 1'b1; step();
    run = 1'b0;
    decode_busy = 1'b0; step();
    vectors++; if (fetch_busy !== 1'b1) begin miscompares++; $display("FAIL stop_mid_busy: got %b want 1", fetch_busy); end
    complete(5'd5);
    vectors++; if (fetch_busy !== 1'b0) begin miscompares++; $display("FAIL stop_idle: got %b want 0", fetch_busy); end
    vectors++; if (pc !== 5'd5 || instr_count !== 16'd3) begin
      miscompares++; $display("FAIL stop_state: got pc %0d count %0d want 5 3", pc, instr_count); end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (decode_start !== 1'b0 || fetch_busy !== 1'b0) bad++;
    end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL stop_stays_idle: got %0d active cycles want 0", bad); end
  endtask

  task automatic test_rst_in_wait();
    logic [58:0] e;
    int n;
    w_c = mk(5'd6, 32'hCAFE);
    do_load(5'd5, w_c);
    exp_q.push_back(with_pc(w_c, 5'd5));
    run = 1'b1;
    wait_start(n);
    e = exp_q.pop_front();
    vectors++; if (instruction !== e) begin miscompares++; $display("FAIL idle_load_seen: got %h want %h", instruction, e); end
    decode_busy = 1'b1; step();
    rst = 1'b1; step(); rst = 1'b0;
    decode_busy = 1'b0; run = 1'b0;
    vectors++; if (pc !== 5'd0) begin miscompares++; $display("FAIL rstw_pc: got %0d want 0", pc); end
    vectors++; if (decode_start !== 1'b0 || fetch_busy !== 1'b0) begin
      miscompares++; $display("FAIL rstw_idle: got start %b busy %b want 0 0", decode_start, fetch_busy); end
    vectors++; if (instr_count !== 16'd0) begin miscompares++; $display("FAIL rstw_count: got %0d want 0", instr_count); end
    exp_q.push_back(with_pc(w_a, 5'd0));
    run = 1'b1;
    wait_start(n);
    vectors++; if (n >= 20) begin miscompares++; $display("FAIL rstw_restart_timeout: got %0d cycles want <20", n); end
    e = exp_q.pop_front();
    vectors++; if (instruction !== e) begin miscompares++; $display("FAIL rstw_mem_intact: got %h want %h", instruction, e); end
    apply_reset();
  endtask

  task automatic test_watchdog();
    int n;
    int bad;
    apply_reset();
    run = 1'b1;
    wait_start(n);
    vectors++; if (decode_start !== 1'b1) begin miscompares++; $display("FAIL wd_start: got %b want 1", decode_start); end
`ifdef FETCH_WATCHDOG_EN
    n = 0;
    while (fault !== 1'b1 && n < 100) begin
      n++;
      step();
    end
    vectors++; if (n != 16) begin miscompares++; $display("FAIL wd_fault_time: got %0d cycles want 16", n); end
    vectors++; if (decode_start !== 1'b0 || fetch_busy !== 1'b0) begin
      miscompares++; $display("FAIL wd_fault_outputs: got start %b busy %b want 0 0", decode_start, fetch_busy); end
    step(); step();
    vectors++; if (fault !== 1'b1) begin miscompares++; $display("FAIL wd_fault_sticky: got %b want 1", fault); end
`else
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (fault !== 1'b0 || decode_start !== 1'b1) bad++;
    end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL wd_absent: got %0d bad cycles want 0", bad); end
`endif
    apply_reset();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_handshake();
    test_wrap_and_stop();
    test_rst_in_wait();
    test_watchdog();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
